video_format_ctrl: RTL

Controller that sequences the CSYNC line-counter datapath and owns the system video-mode decision.
- Consumes per-field line totals from the line counter.
- Debounces the PAL/NTSC classification over several consecutive fields.
- Commits mode changes to downstream consumers (scaler, timing generator) through a req/ack handshake.
- Watches for loss of sync and restarts the measurement datapath.

---
 rtl/video_format_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/video_format_ctrl.sv
// PAL/NTSC mode controller: debounces per-field line totals, commits mode via req/ack, restarts measurement on sync loss.
// Optional LINE_RANGE_CHECK_EN adds a line-total plausibility window and a bad-field loss detector.
module video_format_ctrl #(
    parameter int LOCK_FIELDS      = 4,
    parameter int PAL_THRESH_LINES = 287,
    parameter int TIMEOUT_CYCLES   = 2_000_000,
    parameter int MEAS_RST_CYCLES  = 4
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       field_strobe,
    input  logic [8:0] field_lines,
    input  logic       mode_change_ack,
    output logic       mode_valid,
    output logic       mode_pal,
    output logic       mode_change_req,
    output logic       req_mode_pal,
    output logic       meas_rst,
    output logic       signal_lost,
    output logic [2:0] state_dbg
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MR_W = $clog2(MEAS_RST_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
    localparam logic [MR_W-1:0] MR_INIT = MR_W'(MEAS_RST_CYCLES - 1);
    localparam logic [8:0]      PAL_TH  = 9'(PAL_THRESH_LINES);
    localparam logic [3:0]      LOCK_N  = 4'(LOCK_FIELDS);

    typedef enum logic [2:0] {
        ST_SEARCH  = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_REQ     = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_CHANGE  = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_cand;
    logic            r_cand_vld;
    logic [3:0]      r_match;
    logic [WD_W-1:0] r_wd;
    logic [MR_W-1:0] r_mr_cnt;
    logic            r_meas_rst;
    logic            r_valid;
    logic            r_mode_pal;
    logic            r_req;
    logic            r_req_pal;
    logic            r_lost;

    logic            w_strobe_acc;
    logic            w_cls;
    logic            w_plaus;
    logic            w_timeout;
    logic            w_bad_loss;
    logic            w_loss;
    logic [3:0]      w_match_inc;
    logic            w_lock_done;

    // Strobes arriving while the line counter is held in reset carry no valid total.
    assign w_strobe_acc = field_strobe & ~r_meas_rst;
    assign w_cls        = (field_lines > PAL_TH);
    assign w_timeout    = (r_wd == WD_MAX) & ~field_strobe;
    assign w_match_inc  = (r_match == LOCK_N) ? r_match : r_match + 4'd1;
    assign w_lock_done  = (w_match_inc == LOCK_N);
    assign w_loss       = w_timeout | w_bad_loss;

`ifdef LINE_RANGE_CHECK_EN
    logic [3:0] r_bad_cnt;

    assign w_plaus    = ((field_lines >= 9'd253) && (field_lines <= 9'd272)) ||
                        ((field_lines >= 9'd303) && (field_lines <= 9'd322));
    assign w_bad_loss = w_strobe_acc & ~w_plaus & (r_state == ST_LOCKED) & (r_bad_cnt == 4'd7);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_bad_cnt <= 4'd0;
        end else if (w_loss || (r_state != ST_LOCKED)) begin
            r_bad_cnt <= 4'd0;
        end else if (w_strobe_acc) begin
            if (w_plaus)                r_bad_cnt <= 4'd0;
            else if (r_bad_cnt != 4'hF) r_bad_cnt <= r_bad_cnt + 4'd1;
        end
    end
`else
    assign w_plaus    = 1'b1;
    assign w_bad_loss = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_wd       <= '0;
            r_mr_cnt   <= '0;
            r_meas_rst <= 1'b0;
        end else begin
            if (field_strobe || w_timeout) r_wd <= '0;
            else if (r_wd != WD_MAX)       r_wd <= r_wd + 1'b1;

            if (w_loss) begin
                r_meas_rst <= 1'b1;
                r_mr_cnt   <= MR_INIT;
            end else if (r_mr_cnt != '0) begin
                r_mr_cnt   <= r_mr_cnt - 1'b1;
            end else begin
                r_meas_rst <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state    <= ST_SEARCH;
            r_cand     <= 1'b0;
            r_cand_vld <= 1'b0;
            r_match    <= 4'd0;
            r_valid    <= 1'b0;
            r_mode_pal <= 1'b0;
            r_req      <= 1'b0;
            r_req_pal  <= 1'b0;
            r_lost     <= 1'b0;
        end else if (w_loss) begin
            r_state    <= ST_SEARCH;
            r_cand_vld <= 1'b0;
            r_match    <= 4'd0;
            r_valid    <= 1'b0;
            r_req      <= 1'b0;
            r_lost     <= 1'b1;
        end else begin
            if (w_strobe_acc) r_lost <= 1'b0;
            case (r_state)
                ST_SEARCH: begin
                    if (w_strobe_acc && w_plaus) begin
                        r_cand     <= w_cls;
                        r_cand_vld <= 1'b1;
                        r_match    <= 4'd1;
                        r_state    <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (w_strobe_acc) begin
                        if (!w_plaus) begin
                            r_match    <= 4'd0;
                            r_cand_vld <= 1'b0;
                        end else if (r_cand_vld && (w_cls == r_cand)) begin
                            r_match <= w_match_inc;
                            if (w_lock_done) begin
                                r_state   <= ST_REQ;
                                r_req     <= 1'b1;
                                r_req_pal <= r_cand;
                            end
                        end else begin
                            r_cand     <= w_cls;
                            r_cand_vld <= 1'b1;
                            r_match    <= 4'd1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mode_change_ack) begin
                        r_mode_pal <= r_req_pal;
                        r_valid    <= 1'b1;
                        r_req      <= 1'b0;
                        r_state    <= ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_strobe_acc && w_plaus && (w_cls != r_mode_pal)) begin
                        r_cand     <= w_cls;
                        r_cand_vld <= 1'b1;
                        r_match    <= 4'd1;
                        r_state    <= ST_CHANGE;
                    end
                end
                ST_CHANGE: begin
                    if (w_strobe_acc) begin
                        if (!w_plaus) begin
                            r_match    <= 4'd0;
                            r_cand_vld <= 1'b0;
                        end else if (w_cls == r_mode_pal) begin
                            r_state <= ST_LOCKED;
                        end else if (r_cand_vld) begin
                            r_match <= w_match_inc;
                            if (w_lock_done) begin
                                r_state   <= ST_REQ;
                                r_req     <= 1'b1;
                                r_req_pal <= r_cand;
                            end
                        end else begin
                            r_cand     <= w_cls;
                            r_cand_vld <= 1'b1;
                            r_match    <= 4'd1;
                        end
                    end
                end
                default: r_state <= ST_SEARCH;
            endcase
        end
    end

    assign mode_valid      = r_valid;
    assign mode_pal        = r_mode_pal;
    assign mode_change_req = r_req;
    assign req_mode_pal    = r_req_pal;
    assign meas_rst        = r_meas_rst;
    assign signal_lost     = r_lost;
    assign state_dbg       = r_state;

endmodule
